// File: rtl/cascade_sequencer.sv
// ---------------------------------------------------------------------------
// cascade_sequencer
//
// Cascade controller for an 8259-style PIC. Holds the ICW3 configuration
// (master: slave-present map, slave: own ID) and follows the INTA pulse
// sequence (8080: three pulses, 8086: two pulses). It drives the CAS bus when
// operating as a master, compares it when operating as a slave, and decides
// whether this device drives the vector byte(s) on each pulse.
//
// Optional feature (compile-time macro CASCADE_TIMEOUT_EN):
//   When defined, an INTA sequence that sees no strobe for TIMEOUT_CYCLES
//   clocks is aborted and ack_timeout pulses for one cycle. When undefined the
//   sequence waits indefinitely and ack_timeout is constant 0.
//
// Ports:
//   clock              in   system clock, rising edge
//   reset_n            in   asynchronous active-low reset
//   write_icw1         in   ICW1 write strobe: clears config, aborts sequence
//   write_icw3         in   ICW3 write strobe: loads internal_data_bus
//   internal_data_bus  in   ICW3 value (NUM_IR bits)
//   single_mode        in   ICW1 SNGL (1 = no cascade)
//   buffered_mode      in   ICW4 BUF
//   buffered_master    in   ICW4 M/S (used when buffered_mode = 1)
//   slave_program_n    in   SP pin (used when buffered_mode = 0)
//   mode_8086          in   ICW4 uPM (1 = two-pulse sequence)
//   inta_fall          in   one-cycle strobe, INTA_n falling edge
//   inta_rise          in   one-cycle strobe, INTA_n rising edge
//   acknowledged_irq   in   one-hot IR being acknowledged
//   cascade_in         in   CAS pins, input side
//   cascade_out        out  CAS pins, output side (registered)
//   cascade_oe         out  CAS output enable (registered)
//   cascade_slave      out  1 = device operates as slave (combinational)
//   ack_active         out  INTA sequence in progress (registered)
//   call_opcode_en     out  drive CALL opcode, 8080 first pulse (registered)
//   vector_drive_en    out  this device drives the vector this pulse (registered)
//   ack_timeout        out  one-cycle pulse on timeout abort (registered)
// ---------------------------------------------------------------------------
module cascade_sequencer #(
    parameter int CAS_WIDTH      = 3,
    parameter int NUM_IR         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 write_icw1,
    input  logic                 write_icw3,
    input  logic [NUM_IR-1:0]    internal_data_bus,
    input  logic                 single_mode,
    input  logic                 buffered_mode,
    input  logic                 buffered_master,
    input  logic                 slave_program_n,
    input  logic                 mode_8086,
    input  logic                 inta_fall,
    input  logic                 inta_rise,
    input  logic [NUM_IR-1:0]    acknowledged_irq,
    input  logic [CAS_WIDTH-1:0] cascade_in,
    output logic [CAS_WIDTH-1:0] cascade_out,
    output logic                 cascade_oe,
    output logic                 cascade_slave,
    output logic                 ack_active,
    output logic                 call_opcode_en,
    output logic                 vector_drive_en,
    output logic                 ack_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2,
        ST_P3   = 2'd3
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [CAS_WIDTH-1:0] lowest_index(input logic [NUM_IR-1:0] vec);
        logic [CAS_WIDTH-1:0] idx;
        idx = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            idx = vec[i] ? CAS_WIDTH'(i) : idx;
        end
        return idx;
    endfunction

    state_t               state_r;
    state_t               state_next_s;
    logic [NUM_IR-1:0]    cfg_r;
    logic [NUM_IR-1:0]    cfg_next_s;
    logic [NUM_IR-1:0]    sel_irq_r;
    logic [NUM_IR-1:0]    sel_irq_next_s;
    logic                 match_r;
    logic                 match_next_s;
    logic                 timeout_hit_s;
    logic                 fall_s;
    logic                 rise_only_s;

    logic                 master_s;
    logic                 from_slave_next_s;
    logic                 in_seq_next_s;
    logic                 vec_phase_next_s;
    logic                 oe_next_s;
    logic [CAS_WIDTH-1:0] cas_out_next_s;
    logic                 call_next_s;
    logic                 vde_next_s;

    logic [CAS_WIDTH-1:0] cascade_out_r;
    logic                 cascade_oe_r;
    logic                 ack_active_r;
    logic                 call_opcode_en_r;
    logic                 vector_drive_en_r;
    logic                 ack_timeout_r;

    // A falling edge always wins over a coincident rising edge.
    assign fall_s      = inta_fall;
    assign rise_only_s = inta_rise & ~inta_fall;

    assign cascade_slave = single_mode ? 1'b0
                         : (buffered_mode ? ~buffered_master : ~slave_program_n);
    assign master_s      = ~single_mode & ~cascade_slave;

`ifdef CASCADE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_r;
    logic [TO_W-1:0] to_cnt_next_s;

    // Quiet-cycle counter: restarts on any strobe, outside a sequence, or on ICW1.
    always_comb begin
        to_cnt_next_s = '0;
        timeout_hit_s = 1'b0;
        if ((state_r == ST_IDLE) || inta_fall || inta_rise || write_icw1) begin
            to_cnt_next_s = '0;
            timeout_hit_s = 1'b0;
        end else begin
            to_cnt_next_s = to_cnt_r + TO_W'(1);
            timeout_hit_s = (to_cnt_next_s == TO_W'(TIMEOUT_CYCLES));
        end
    end

    // Quiet-cycle counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_next_s;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next config, sequence state and per-sequence latches.
    always_comb begin
        cfg_next_s     = cfg_r;
        state_next_s   = state_r;
        sel_irq_next_s = sel_irq_r;
        match_next_s   = match_r;

        if (write_icw1) begin
            cfg_next_s = '0;
        end else if (write_icw3) begin
            cfg_next_s = internal_data_bus;
        end else begin
            cfg_next_s = cfg_r;
        end

        if (write_icw1) begin
            state_next_s   = ST_IDLE;
            sel_irq_next_s = '0;
            match_next_s   = 1'b0;
        end else if (timeout_hit_s) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        state_next_s   = ST_P1;
                        sel_irq_next_s = acknowledged_irq;
                        match_next_s   = 1'b0;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_P1: begin
                    if (fall_s) begin
                        state_next_s = ST_P2;
                        // The master presents the slave ID during the first
                        // pulse; it is sampled on the second falling edge.
                        match_next_s = cascade_slave &
                                       (cascade_in == cfg_r[CAS_WIDTH-1:0]);
                    end else begin
                        state_next_s = ST_P1;
                    end
                end
                ST_P2: begin
                    if (fall_s && !mode_8086) begin
                        state_next_s = ST_P3;
                    end else if (rise_only_s && mode_8086) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_P2;
                    end
                end
                ST_P3: begin
                    if (rise_only_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_P3;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output values for the state being entered, so the registered outputs
    // change on the same edge as the state.
    always_comb begin
        from_slave_next_s = master_s & (|(sel_irq_next_s & cfg_next_s));
        in_seq_next_s     = (state_next_s != ST_IDLE);
        if (mode_8086) begin
            vec_phase_next_s = (state_next_s == ST_P2);
        end else begin
            vec_phase_next_s = (state_next_s == ST_P2) || (state_next_s == ST_P3);
        end

        oe_next_s = in_seq_next_s & from_slave_next_s;
        if (oe_next_s) begin
            cas_out_next_s = lowest_index(sel_irq_next_s & cfg_next_s);
        end else begin
            cas_out_next_s = '0;
        end

        call_next_s = (state_next_s == ST_P1) & ~mode_8086 & ~cascade_slave;

        vde_next_s = vec_phase_next_s &
                     (single_mode |
                      (master_s & ~from_slave_next_s) |
                      (cascade_slave & match_next_s));
    end

    // State, configuration and latch registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cfg_r     <= '0;
            sel_irq_r <= '0;
            match_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cfg_r     <= cfg_next_s;
            sel_irq_r <= sel_irq_next_s;
            match_r   <= match_next_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cascade_out_r     <= '0;
            cascade_oe_r      <= 1'b0;
            ack_active_r      <= 1'b0;
            call_opcode_en_r  <= 1'b0;
            vector_drive_en_r <= 1'b0;
            ack_timeout_r     <= 1'b0;
        end else begin
            cascade_out_r     <= cas_out_next_s;
            cascade_oe_r      <= oe_next_s;
            ack_active_r      <= in_seq_next_s;
            call_opcode_en_r  <= call_next_s;
            vector_drive_en_r <= vde_next_s;
            ack_timeout_r     <= timeout_hit_s & ~write_icw1;
        end
    end

    assign cascade_out     = cascade_out_r;
    assign cascade_oe      = cascade_oe_r;
    assign ack_active      = ack_active_r;
    assign call_opcode_en  = call_opcode_en_r;
    assign vector_drive_en = vector_drive_en_r;
    assign ack_timeout     = ack_timeout_r;

endmodule
